wide_add_sequencer: RTL and testbench

Multi-cycle controller that performs a WIDTH-bit addition by time-sharing one instance of the team's `ripple_carry_adder_4bit`, one nibble per clock, LSB nibble first. The 4-bit adder's carry-out is registered and fed back as the next nibble's carry-in. Operands enter and results leave over ready/valid handshakes. The block sits between an operand producer and a result consumer, and is the sequencing front-end for the 4-bit adder datapath.

---
 rtl/wide_add_sequencer.sv | 133 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit ripple adder, LSB nibble first,
// with the inter-nibble carry held in carry_q and ready/valid on both sides.

module ripple_carry_adder_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [4:0] carry;

   assign carry[0] = cin_i;

   for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
   end

   assign cout_o = carry[4];
endmodule

module wide_add_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int NIB   = WIDTH / 4;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, sum_q;
   logic [WIDTH-1:0] a_sh_d, b_sh_d, acc_d;
   logic             carry_q, cout_q;
   logic [CNT_W-1:0] nib_cnt_q;
   logic             in_ready_q, out_valid_q, busy_q;

   logic [3:0]       add_sum;
   logic             add_cout;

   ripple_carry_adder_4bit u_adder (
      .a_i    (a_sh_q[3:0]),
      .b_i    (b_sh_q[3:0]),
      .cin_i  (carry_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // Each nibble result enters at the top, so after NIB shifts nibble 0 sits at bits [3:0].
   if (WIDTH > 4) begin : g_wide
      assign acc_d  = {add_sum, acc_q[WIDTH-1:4]};
      assign a_sh_d = {4'b0000, a_sh_q[WIDTH-1:4]};
      assign b_sh_d = {4'b0000, b_sh_q[WIDTH-1:4]};
   end else begin : g_single
      assign acc_d  = add_sum;
      assign a_sh_d = '0;
      assign b_sh_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         nib_cnt_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_sh_q     <= a;
                  b_sh_q     <= b;
                  carry_q    <= cin;
                  nib_cnt_q  <= '0;
                  acc_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               carry_q <= add_cout;
               a_sh_q  <= a_sh_d;
               b_sh_q  <= b_sh_d;
               if (nib_cnt_q == LAST_NIB) begin
                  sum_q       <= acc_d;
                  cout_q      <= add_cout;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  nib_cnt_q <= nib_cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: a 16-bit and a 4-bit instance on one clock,
// checked with immediate assertions against hand-computed sums.

module tb_wide_add_sequencer;
   logic clk = 1'b0;
   logic rst;

   logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16, busy16;
   logic [15:0] a16, b16, sum16;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
   logic [3:0]  a4, b4, sum4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wide_add_sequencer #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16),
      .out_valid(out_valid16), .out_ready(out_ready16),
      .sum(sum16), .cout(cout16), .busy(busy16)
   );

   wide_add_sequencer #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .cout(cout4), .busy(busy4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic [15:0] es, input logic ec, input string tag);
      int lat;
      a16 = av; b16 = bv; cin16 = cv; in_valid16 = 1'b1;
      check({tag, "_in_ready"}, in_ready16, 1);
      step();
      in_valid16 = 1'b0;
      check({tag, "_busy"}, busy16, 1);
      lat = 0;
      while (!out_valid16 && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_sum"}, sum16, es);
      check({tag, "_cout"}, cout16, ec);
      $display("[TB] %s a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", tag, av, bv, cv, sum16, cout16, lat);
      if (out_ready16) begin
         step();
         check({tag, "_release_valid"}, out_valid16, 0);
         check({tag, "_release_ready"}, in_ready16, 1);
         check({tag, "_sum_held"}, sum16, es);
      end
   endtask

   task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                       input logic [3:0] es, input logic ec, input string tag);
      int lat;
      a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1; out_ready4 = 1'b1;
      check({tag, "_in_ready"}, in_ready4, 1);
      step();
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, 1);
      check({tag, "_sum"}, sum4, es);
      check({tag, "_cout"}, cout4, ec);
      $display("[TB] %s a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", tag, av, bv, cv, sum4, cout4, lat);
      step();
      check({tag, "_release_valid"}, out_valid4, 0);
   endtask

   initial begin
      int n_acc, n_res;
      int acc_cyc [2];
      logic [15:0] res_sum [2];
      logic        res_cout [2];
      logic        hs;

      rst = 1'b1;
      in_valid16 = 0; out_ready16 = 0; cin16 = 0; a16 = '0; b16 = '0;
      in_valid4 = 0;  out_ready4 = 0;  cin4 = 0;  a4 = '0;  b4 = '0;
      #3;
      check("rst_in_ready", in_ready16, 1);
      check("rst_out_valid", out_valid16, 0);
      check("rst_busy", busy16, 0);
      check("rst_sum", sum16, 0);
      check("rst_cout", cout16, 0);
      step();
      rst = 1'b0;
      step();

      // Basic add, consumer always ready
      out_ready16 = 1'b1;
      run16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");

      // Reset two RUN cycles into an operation; previous result must be wiped
      a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; in_valid16 = 1'b1;
      step();
      in_valid16 = 1'b0;
      step();
      step();
      check("midrun_busy_before", busy16, 1);
      rst = 1'b1;
      #1;
      check("midrun_rst_out_valid", out_valid16, 0);
      check("midrun_rst_busy", busy16, 0);
      check("midrun_rst_sum", sum16, 0);
      check("midrun_rst_cout", cout16, 0);
      #2;
      rst = 1'b0;
      step();
      check("midrun_release_in_ready", in_ready16, 1);
      check("midrun_release_out_valid", out_valid16, 0);
      run16(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, "after_reset");

      // Carry through every nibble boundary
      run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple_b1");
      run16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple_cin");
      run16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb_carry");

      // Backpressure: result held, new operands ignored
      out_ready16 = 1'b0;
      run16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "bp");
      a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b1; in_valid16 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("bp_hold%0d_valid", i), out_valid16, 1);
         check($sformatf("bp_hold%0d_sum", i), sum16, 16'h0100);
         check($sformatf("bp_hold%0d_in_ready", i), in_ready16, 0);
      end
      $display("[TB] bp held 5 cycles sum=%h out_valid=%0d in_ready=%0d", sum16, out_valid16, in_ready16);
      out_ready16 = 1'b1;
      in_valid16 = 1'b0;
      step();
      check("bp_release_valid", out_valid16, 0);
      step();
      step();
      check("bp_no_capture_busy", busy16, 0);
      check("bp_no_capture_in_ready", in_ready16, 1);
      check("bp_no_capture_sum", sum16, 16'h0100);

      // Back-to-back with both handshakes held high
      n_acc = 0; n_res = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      res_sum[0] = '0; res_sum[1] = '0; res_cout[0] = 1'b1; res_cout[1] = 1'b1;
      a16 = 16'h0001; b16 = 16'h0002; cin16 = 1'b0; in_valid16 = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         hs = in_ready16 && in_valid16;
         step();
         if (hs && n_acc < 2) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc == 1) begin
               a16 = 16'h7FFF; b16 = 16'h0001;
            end else begin
               in_valid16 = 1'b0;
            end
         end
         if (out_valid16 && n_res < 2) begin
            res_sum[n_res] = sum16;
            res_cout[n_res] = cout16;
            $display("[TB] b2b result %0d sum=%h cout=%0d at cycle %0d", n_res, sum16, cout16, cyc);
            n_res++;
         end
      end
      in_valid16 = 1'b0;
      check("b2b_accepts", n_acc, 2);
      check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 6);
      check("b2b_results", n_res, 2);
      check("b2b_sum0", res_sum[0], 16'h0003);
      check("b2b_cout0", res_cout[0], 0);
      check("b2b_sum1", res_sum[1], 16'h8000);
      check("b2b_cout1", res_cout[1], 0);

      // Single-nibble instance
      run4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, "w4_carry");
      run4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, "w4_nocarry");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
